sar_scan_ctrl: RTL and testbench

- Multi-channel scan sequencer that shares the single fsm_sar_bs SAR converter between NCh analog inputs.
- Selects each enabled channel on the analog mux, waits a settling interval, then pulses the converter start.
- Waits for end-of-conversion, then publishes the result tagged with its channel number.
- Sits between the top-level control pins and the fsm_sar_bs instance; supports one-shot and continuous round-robin scans.

---
 rtl/sar_scan_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_sar_scan_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_scan_ctrl.sv
// sar_scan_ctrl
// Multi-channel scan sequencer in front of a single shared SAR converter
// (fsm_sar_bs). Each enabled channel is selected on the analog mux, allowed
// to settle, converted, and its result published tagged with the channel
// number. Supports one-shot scans and continuous round-robin scanning.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   go_i           start a scan (IDLE only)
//   cont_i         1 = restart after each completed scan
//   stop_i         stop after the conversion in progress
//   chan_mask_i    enabled channels, latched at each scan start
//   eoc_i          end of conversion from the SAR
//   result_i       SAR result, valid with eoc_i
//   start_o        one-cycle SAR start pulse
//   mux_sel_o      analog mux select
//   data_o         last captured result
//   data_ch_o      channel of data_o, or of the last timeout
//   data_valid_o   pulse: data_o/data_ch_o updated
//   timeout_o      pulse: conversion on data_ch_o abandoned
//   scan_done_o    pulse: every latched channel visited
//   busy_o         sequencer not idle
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for go_i with a non-zero mask
// SETTLE | mux switched, waiting SettleCycles for the input to settle
// START  | start_o asserted for this single cycle
// WAIT   | waiting for eoc_i or the conversion timeout

module sar_scan_ctrl #(
    parameter int Width         = 6,
    parameter int NCh           = 4,
    parameter int ChW           = 2,
    parameter int SettleCycles  = 2,
    parameter int TimeoutCycles = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             go_i,
    input  logic             cont_i,
    input  logic             stop_i,
    input  logic [NCh-1:0]   chan_mask_i,
    input  logic             eoc_i,
    input  logic [Width-1:0] result_i,
    output logic             start_o,
    output logic [ChW-1:0]   mux_sel_o,
    output logic [Width-1:0] data_o,
    output logic [ChW-1:0]   data_ch_o,
    output logic             data_valid_o,
    output logic             timeout_o,
    output logic             scan_done_o,
    output logic             busy_o
);

    localparam int SW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
    localparam int TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    // SettleCycles = 0 still spends one cycle in SETTLE, same as 1.
    localparam logic [SW-1:0] SETTLE_LOAD = (SettleCycles > 0) ? SW'(SettleCycles - 1) : '0;
    localparam logic [TW-1:0] TO_LOAD     = TW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_START,
        S_WAIT
    } state_t;

    state_t           r_state;
    logic [NCh-1:0]   r_mask;
    logic [ChW-1:0]   r_mux_sel;
    logic             r_stop_req;
    logic [SW-1:0]    r_settle_cnt;
    logic [TW-1:0]    r_to_cnt;
    logic [Width-1:0] r_data;
    logic [ChW-1:0]   r_data_ch;
    logic             r_data_valid;
    logic             r_timeout;
    logic             r_scan_done;

    state_t           w_state_nxt;
    logic [NCh-1:0]   w_mask_nxt;
    logic [ChW-1:0]   w_mux_nxt;
    logic             w_stop_nxt;
    logic [SW-1:0]    w_settle_nxt;
    logic [TW-1:0]    w_to_nxt;
    logic [Width-1:0] w_data_nxt;
    logic [ChW-1:0]   w_data_ch_nxt;
    logic             w_dv_nxt;
    logic             w_to_pulse_nxt;
    logic             w_done_nxt;
    logic             w_advance;

    logic             w_has_next;
    logic [ChW-1:0]   w_next_ch;
    logic [ChW-1:0]   w_first_ch;

    // Next enabled channel above the current one; descending loop so the
    // lowest qualifying index is the one left assigned.
    always_comb begin
        w_has_next = 1'b0;
        w_next_ch  = '0;
        for (int i = NCh - 1; i >= 0; i--) begin
            if (r_mask[i] && (i > int'(r_mux_sel))) begin
                w_has_next = 1'b1;
                w_next_ch  = ChW'(i);
            end
        end
    end

    always_comb begin
        w_first_ch = '0;
        for (int i = NCh - 1; i >= 0; i--) begin
            if (chan_mask_i[i]) begin
                w_first_ch = ChW'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_mask_nxt     = r_mask;
        w_mux_nxt      = r_mux_sel;
        w_stop_nxt     = r_stop_req | (stop_i && (r_state != S_IDLE));
        w_settle_nxt   = r_settle_cnt;
        w_to_nxt       = r_to_cnt;
        w_data_nxt     = r_data;
        w_data_ch_nxt  = r_data_ch;
        w_dv_nxt       = 1'b0;
        w_to_pulse_nxt = 1'b0;
        w_done_nxt     = 1'b0;
        w_advance      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_stop_nxt = 1'b0;
                if (go_i && (|chan_mask_i)) begin
                    w_mask_nxt   = chan_mask_i;
                    w_mux_nxt    = w_first_ch;
                    w_settle_nxt = SETTLE_LOAD;
                    w_state_nxt  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_settle_cnt == '0) begin
                    w_state_nxt = S_START;
                end else begin
                    w_settle_nxt = r_settle_cnt - SW'(1);
                end
            end
            S_START: begin
                w_to_nxt    = TO_LOAD;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // eoc has priority over a timeout landing in the same cycle.
                if (eoc_i) begin
                    w_data_nxt    = result_i;
                    w_data_ch_nxt = r_mux_sel;
                    w_dv_nxt      = 1'b1;
                    w_advance     = 1'b1;
                end else if (r_to_cnt == '0) begin
                    w_data_ch_nxt  = r_mux_sel;
                    w_to_pulse_nxt = 1'b1;
                    w_advance      = 1'b1;
                end else begin
                    w_to_nxt = r_to_cnt - TW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_advance) begin
            // A stop raised in the final WAIT cycle is honoured too.
            if (r_stop_req || stop_i) begin
                w_state_nxt = S_IDLE;
                w_stop_nxt  = 1'b0;
            end else if (w_has_next) begin
                w_mux_nxt    = w_next_ch;
                w_settle_nxt = SETTLE_LOAD;
                w_state_nxt  = S_SETTLE;
            end else begin
                w_done_nxt = 1'b1;
                if (cont_i && (|chan_mask_i)) begin
                    w_mask_nxt   = chan_mask_i;
                    w_mux_nxt    = w_first_ch;
                    w_settle_nxt = SETTLE_LOAD;
                    w_state_nxt  = S_SETTLE;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_stop_nxt  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_mask       <= '0;
            r_mux_sel    <= '0;
            r_stop_req   <= 1'b0;
            r_settle_cnt <= '0;
            r_to_cnt     <= '0;
            r_data       <= '0;
            r_data_ch    <= '0;
            r_data_valid <= 1'b0;
            r_timeout    <= 1'b0;
            r_scan_done  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_mask       <= w_mask_nxt;
            r_mux_sel    <= w_mux_nxt;
            r_stop_req   <= w_stop_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_to_cnt     <= w_to_nxt;
            r_data       <= w_data_nxt;
            r_data_ch    <= w_data_ch_nxt;
            r_data_valid <= w_dv_nxt;
            r_timeout    <= w_to_pulse_nxt;
            r_scan_done  <= w_done_nxt;
        end
    end

    assign start_o      = (r_state == S_START);
    assign busy_o       = (r_state != S_IDLE);
    assign mux_sel_o    = r_mux_sel;
    assign data_o       = r_data;
    assign data_ch_o    = r_data_ch;
    assign data_valid_o = r_data_valid;
    assign timeout_o    = r_timeout;
    assign scan_done_o  = r_scan_done;

endmodule

// File: tb/tb_sar_scan_ctrl.sv
// Directed bench for sar_scan_ctrl with a small SAR converter model that
// answers each start_o with eoc after a programmable delay, result 10+channel.
module tb_sar_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst, go, cont, stop;
    logic [3:0] mask;
    logic       eoc;
    logic [5:0] result;
    logic       start_o;
    logic [1:0] mux_sel_o;
    logic [5:0] data_o;
    logic [1:0] data_ch_o;
    logic       data_valid_o, timeout_o, scan_done_o, busy_o;

    sar_scan_ctrl #(
        .Width(6), .NCh(4), .ChW(2), .SettleCycles(2), .TimeoutCycles(32)
    ) dut (
        .clk_i(clk), .rst_i(rst), .go_i(go), .cont_i(cont), .stop_i(stop),
        .chan_mask_i(mask), .eoc_i(eoc), .result_i(result),
        .start_o(start_o), .mux_sel_o(mux_sel_o), .data_o(data_o),
        .data_ch_o(data_ch_o), .data_valid_o(data_valid_o),
        .timeout_o(timeout_o), .scan_done_o(scan_done_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // converter model
    bit model_en  = 1'b0;
    int model_dly = 6;
    int pend      = 0;

    initial begin
        eoc    = 1'b0;
        result = '0;
        forever begin
            @(posedge clk);
            #1;
            eoc = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    eoc    = 1'b1;
                    result = 6'(10 + int'(mux_sel_o));
                end
            end
            if (start_o && model_en) pend = model_dly;
        end
    end

    // event monitor
    int dv_cyc[$], dv_ch[$], dv_data[$];
    int to_cyc[$], to_ch[$], done_cyc[$], start_cyc[$];
    int start_double = 0;
    bit prev_start   = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (data_valid_o) begin
                dv_cyc.push_back(cyc);
                dv_ch.push_back(int'(data_ch_o));
                dv_data.push_back(int'(data_o));
            end
            if (timeout_o) begin
                to_cyc.push_back(cyc);
                to_ch.push_back(int'(data_ch_o));
            end
            if (scan_done_o) done_cyc.push_back(cyc);
            if (start_o) start_cyc.push_back(cyc);
            if (start_o && prev_start) start_double++;
            prev_start = start_o;
        end
    end

    task automatic clear_log();
        dv_cyc.delete(); dv_ch.delete(); dv_data.delete();
        to_cyc.delete(); to_ch.delete(); done_cyc.delete(); start_cyc.delete();
    endtask

    task automatic pulse_go(input logic [3:0] m, input logic c, output int t0);
        mask = m;
        cont = c;
        go   = 1'b1;
        t0   = cyc;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, int'(busy_o), 0);
    endtask

    int t0, s0, n;

    initial begin
        rst = 1'b1; go = 1'b0; cont = 1'b0; stop = 1'b0; mask = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  int'(busy_o), 0);
        chk("rst_start", int'(start_o), 0);
        chk("rst_mux",   int'(mux_sel_o), 0);
        chk("rst_data",  int'(data_o), 0);
        chk("rst_ch",    int'(data_ch_o), 0);
        chk("rst_dv",    int'(data_valid_o), 0);
        chk("rst_to",    int'(timeout_o), 0);
        chk("rst_done",  int'(scan_done_o), 0);
        rst = 1'b0;
        @(negedge clk);

        // single scan, mask 1011
        model_en = 1'b1; model_dly = 6;
        clear_log();
        pulse_go(4'b1011, 1'b0, t0);
        chk("ss_busy_c1", int'(busy_o), 1);
        chk("ss_mux_c1",  int'(mux_sel_o), 0);
        wait_idle("ss_idle", 100);
        chk("ss_dv_n", dv_ch.size(), 3);
        if (dv_ch.size() == 3) begin
            chk("ss_ch0", dv_ch[0], 0);   chk("ss_d0", dv_data[0], 10);
            chk("ss_ch1", dv_ch[1], 1);   chk("ss_d1", dv_data[1], 11);
            chk("ss_ch2", dv_ch[2], 3);   chk("ss_d2", dv_data[2], 13);
            chk("ss_dv0_cyc", dv_cyc[0], t0 + 10);
            chk("ss_done_cyc", (done_cyc.size() > 0) ? done_cyc[0] : -1, dv_cyc[2]);
        end
        chk("ss_done_n", done_cyc.size(), 1);
        chk("ss_to_n", to_cyc.size(), 0);
        chk("ss_start_n", start_cyc.size(), 3);
        if (start_cyc.size() >= 2) begin
            chk("ss_start0_cyc", start_cyc[0], t0 + 3);
            chk("ss_start1_cyc", start_cyc[1], t0 + 12);
        end
        chk("ss_start_width", start_double, 0);
        chk("ss_mux_hold", int'(mux_sel_o), 3);

        // timeout, mask 0001, converter silent
        model_en = 1'b0;
        clear_log();
        pulse_go(4'b0001, 1'b0, t0);
        wait_idle("to_idle", 100);
        chk("to_n", to_cyc.size(), 1);
        chk("to_dv_n", dv_cyc.size(), 0);
        chk("to_done_n", done_cyc.size(), 1);
        if (to_cyc.size() == 1) begin
            chk("to_ch", to_ch[0], 0);
            chk("to_cyc", to_cyc[0], t0 + 36);
            chk("to_done_same", (done_cyc.size() > 0) ? done_cyc[0] : -1, to_cyc[0]);
        end
        chk("to_data_kept", int'(data_o), 13);

        // eoc arriving exactly on the timeout cycle wins
        model_en = 1'b1; model_dly = 32;
        clear_log();
        pulse_go(4'b0001, 1'b0, t0);
        wait_idle("eto_idle", 100);
        chk("eto_to_n", to_cyc.size(), 0);
        chk("eto_dv_n", dv_cyc.size(), 1);
        if (dv_cyc.size() == 1) begin
            chk("eto_dv_cyc", dv_cyc[0], t0 + 36);
            chk("eto_data", dv_data[0], 10);
        end

        // continuous, mask 0110, stop during a channel-2 WAIT
        model_dly = 6;
        clear_log();
        pulse_go(4'b0110, 1'b1, t0);
        n = 0;
        while (done_cyc.size() < 2 && n < 300) begin @(negedge clk); n++; end
        chk("cs_two_passes", done_cyc.size(), 2);
        n = 0;
        while (!(start_o && mux_sel_o == 2'd2) && n < 50) begin @(negedge clk); n++; end
        chk("cs_ch2_start", int'(start_o), 1);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle("cs_idle", 100);
        cont = 1'b0;
        repeat (20) @(negedge clk);
        chk("cs_dv_n", dv_ch.size(), 6);
        chk("cs_done_n", done_cyc.size(), 2);
        if (dv_ch.size() == 6) begin
            chk("cs_ch0", dv_ch[0], 1);
            chk("cs_ch1", dv_ch[1], 2);
            chk("cs_ch2", dv_ch[2], 1);
            chk("cs_ch3", dv_ch[3], 2);
            chk("cs_last_ch", dv_ch[5], 2);
            chk("cs_last_data", dv_data[5], 12);
        end
        chk("cs_busy_after", int'(busy_o), 0);

        // reset mid-WAIT, late eoc ignored
        clear_log();
        pulse_go(4'b0001, 1'b0, t0);
        n = 0;
        while (!start_o && n < 50) begin @(negedge clk); n++; end
        chk("rw_start_seen", int'(start_o), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rw_busy",  int'(busy_o), 0);
        chk("rw_mux",   int'(mux_sel_o), 0);
        chk("rw_data",  int'(data_o), 0);
        chk("rw_ch",    int'(data_ch_o), 0);
        chk("rw_dv",    int'(data_valid_o), 0);
        chk("rw_to",    int'(timeout_o), 0);
        chk("rw_done",  int'(scan_done_o), 0);
        rst = 1'b0;
        clear_log();
        repeat (10) @(negedge clk);
        chk("rw_late_eoc", dv_cyc.size(), 0);
        chk("rw_idle", int'(busy_o), 0);

        // go with zero mask is ignored
        clear_log();
        pulse_go(4'b0000, 1'b0, t0);
        chk("zm_busy", int'(busy_o), 0);
        repeat (5) @(negedge clk);
        chk("zm_busy_later", int'(busy_o), 0);
        chk("zm_starts", start_cyc.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
